// File: rtl/uart_fb_reader.sv
// rtl/uart_fb_reader.sv - streams a full framebuffer out over a UART link, 8N1, one word at a time
module uart_fb_reader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int X_WORDS      = 20,
    parameter int Y_LINES      = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] fb_data_in,
    input  logic        fb_data_ready,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic        read,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [9:0]    X_LAST    = 10'(X_WORDS - 1);
    localparam logic [9:0]    Y_LAST    = 10'(Y_LINES - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REQ       = 3'd1;
    localparam logic [2:0] WAIT      = 3'd2;
    localparam logic [2:0] START_BIT = 3'd3;
    localparam logic [2:0] DATA_BITS = 3'd4;
    localparam logic [2:0] STOP_BIT  = 3'd5;
    localparam logic [2:0] NEXT      = 3'd6;

    logic [2:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [1:0]    byte_idx;
    logic [31:0]   shreg;
    logic          bit_end;

    // the current serial bit has been held for its full CLKS_PER_BIT cycles
    assign bit_end = (baud_cnt == BAUD_LAST);

    // read strobe is simply the one-cycle REQ state
    assign read = (state == REQ);

    // line level: low for start bit, LSB of the shift register during data, idle high otherwise
    always_comb begin
        tx = 1'b1;
        case (state)
            START_BIT: tx = 1'b0;
            DATA_BITS: tx = shreg[0];
            default:   tx = 1'b1;
        endcase
    end

    // frame walk, word fetch and byte serialisation
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            shreg    <= '0;
            x_pos    <= '0;
            y_pos    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        x_pos <= '0;
                        y_pos <= '0;
                        busy  <= 1'b1;
                        state <= REQ;
                    end
                end
                REQ: state <= WAIT;
                WAIT: begin
                    if (fb_data_ready) begin
                        shreg    <= fb_data_in;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud_cnt <= '0;
                        state    <= START_BIT;
                    end
                end
                START_BIT: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    if (bit_end) begin
                        bit_idx <= '0;
                        state   <= DATA_BITS;
                    end
                end
                DATA_BITS: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    if (bit_end) begin
                        // after eight shifts the next byte of the word sits in [7:0]
                        shreg   <= {1'b0, shreg[31:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                        end
                    end
                end
                STOP_BIT: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    if (bit_end) begin
                        if (byte_idx == 2'd3) begin
                            state <= NEXT;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= START_BIT;
                        end
                    end
                end
                NEXT: begin
                    if (x_pos != X_LAST) begin
                        x_pos <= x_pos + 1'b1;
                        state <= REQ;
                    end else if (y_pos != Y_LAST) begin
                        x_pos <= '0;
                        y_pos <= y_pos + 1'b1;
                        state <= REQ;
                    end else begin
                        x_pos <= '0;
                        y_pos <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fb_reader.sv
// tb/tb_uart_fb_reader.sv - scoreboard bench for uart_fb_reader with a UART receiver and framebuffer model
module tb_uart_fb_reader;

    localparam int CPB = 4;
    localparam int XW  = 2;
    localparam int YL  = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] fb_data_in = '0;
    logic        fb_data_ready = 1'b0;
    logic [9:0]  x_pos, y_pos;
    logic        read, tx, busy, done;

    uart_fb_reader #(.CLKS_PER_BIT(CPB), .X_WORDS(XW), .Y_LINES(YL)) dut (
        .clk(clk), .reset(reset), .start(start),
        .fb_data_in(fb_data_in), .fb_data_ready(fb_data_ready),
        .x_pos(x_pos), .y_pos(y_pos), .read(read),
        .tx(tx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_bytes[$];
    logic [19:0] exp_addr[$];
    logic [31:0] word_q[$];
    int fb_delay    = 2;
    int spurious_en = 0;
    int rx_gen      = 0;
    int rx_count    = 0;
    int done_count  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic fail_event(input string name);
        total++;
        bad++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    // framebuffer model: answers each read after fb_delay cycles, optionally injects stray ready pulses
    initial begin
        logic [9:0]  ax, ay;
        logic        stable_ok, tx_ok, noread_ok;
        logic [31:0] w;
        forever begin
            @(negedge clk);
            fb_data_ready = 1'b0;
            if (read === 1'b1) begin
                ax = x_pos; ay = y_pos;
                stable_ok = 1'b1; tx_ok = 1'b1; noread_ok = 1'b1;
                for (int i = 0; i < fb_delay; i++) begin
                    @(negedge clk);
                    if (x_pos !== ax || y_pos !== ay) stable_ok = 1'b0;
                    if (tx !== 1'b1) tx_ok = 1'b0;
                    if (read !== 1'b0) noread_ok = 1'b0;
                end
                chk("addr_stable_wait", stable_ok, 1'b1);
                chk("tx_idle_wait", tx_ok, 1'b1);
                chk("read_once_wait", noread_ok, 1'b1);
                w = (word_q.size() > 0) ? word_q.pop_front() : $urandom;
                for (int b = 0; b < 4; b++) exp_bytes.push_back(w[8*b +: 8]);
                fb_data_in    = w;
                fb_data_ready = 1'b1;
            end else if (spurious_en != 0 && $urandom_range(0, 2) == 0) begin
                fb_data_in    = $urandom;
                fb_data_ready = 1'b1;
            end
        end
    end

    // UART receiver: samples every cycle of each bit so bit length and framing are checked too
    initial begin
        logic [7:0] v;
        logic       hold_ok, frame_ok;
        int         g;
        forever begin
            @(negedge clk);
            if (tx === 1'b0) begin
                g = rx_gen; hold_ok = 1'b1; frame_ok = 1'b1; v = '0;
                for (int c = 1; c < CPB; c++) begin
                    @(negedge clk);
                    if (tx !== 1'b0) frame_ok = 1'b0;
                end
                for (int b = 0; b < 8; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        @(negedge clk);
                        if (c == 0) v[b] = tx;
                        else if (tx !== v[b]) hold_ok = 1'b0;
                    end
                end
                for (int c = 0; c < CPB; c++) begin
                    @(negedge clk);
                    if (tx !== 1'b1) frame_ok = 1'b0;
                end
                if (g == rx_gen) begin
                    if (exp_bytes.size() == 0) fail_event("rx_unexpected_byte");
                    else chk("rx_byte", {hold_ok, frame_ok, v}, {2'b11, exp_bytes.pop_front()});
                    rx_count++;
                end
            end
        end
    end

    // read monitor: addresses must follow raster order, strobe one cycle wide
    initial begin
        logic prev_read = 1'b0;
        forever begin
            @(negedge clk);
            if (read === 1'b1) begin
                chk("read_single", prev_read, 1'b0);
                if (exp_addr.size() == 0) fail_event("read_unexpected");
                else chk("read_addr", {y_pos, x_pos}, exp_addr.pop_front());
            end
            prev_read = read;
        end
    end

    // done monitor: busy must fall in the same cycle as the done pulse
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                chk("busy_with_done", busy, 1'b0);
            end
        end
    end

    task automatic push_frame();
        for (int y = 0; y < YL; y++)
            for (int x = 0; x < XW; x++)
                exp_addr.push_back({10'(y), 10'(x)});
    endtask

    task automatic pulse_start();
        push_frame();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_pos", {y_pos, x_pos}, 20'd0);
    endtask

    task automatic wait_done(input int bound, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", seen, 1'b1);
    endtask

    task automatic end_of_dump(input int r0, input int d0);
        repeat (3) @(negedge clk);
        chk("byte_count", rx_count - r0, XW * YL * 4);
        chk("done_count", done_count - d0, 1);
        chk("addr_drained", exp_addr.size(), 0);
        chk("bytes_drained", exp_bytes.size(), 0);
    endtask

    initial begin
        int   r0, d0;
        logic seen;

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_read", read, 1'b0);
        chk("rst_pos", {y_pos, x_pos}, 20'd0);
        reset = 1'b0;
        @(negedge clk);

        // known word first, then random words for the rest of the frame
        word_q.push_back(32'hA5C3_0F81);
        r0 = rx_count; d0 = done_count;
        pulse_start();
        wait_done(2000, seen);
        end_of_dump(r0, d0);

        // start held through the whole dump, released when done shows
        r0 = rx_count; d0 = done_count;
        push_frame();
        start = 1'b1;
        wait_done(2000, seen);
        start = 1'b0;
        end_of_dump(r0, d0);
        repeat (20) @(negedge clk);
        chk("no_restart_busy", busy, 1'b0);

        // second start after done begins again from (0,0)
        r0 = rx_count; d0 = done_count;
        pulse_start();
        wait_done(2000, seen);
        end_of_dump(r0, d0);

        // slow framebuffer and stray ready pulses during transmission
        fb_delay = 50; spurious_en = 1;
        r0 = rx_count; d0 = done_count;
        pulse_start();
        wait_done(4000, seen);
        end_of_dump(r0, d0);
        fb_delay = 2; spurious_en = 0;

        // reset in the data bits of byte 2 of the first word
        r0 = rx_count; d0 = done_count;
        pulse_start();
        for (int i = 0; i < 500 && rx_count < r0 + 2; i++) @(negedge clk);
        chk("two_bytes_before_reset", rx_count - r0, 2);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        rx_gen++;
        @(negedge clk);
        exp_bytes.delete();
        exp_addr.delete();
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_pos", {y_pos, x_pos}, 20'd0);
        chk("abort_read", read, 1'b0);
        reset = 1'b0;
        r0 = rx_count;
        repeat (300) @(negedge clk);
        chk("abort_no_bytes", rx_count - r0, 0);
        chk("abort_no_done", done_count - d0, 0);
        chk("abort_tx_idle", tx, 1'b1);

        // recovers cleanly with a random frame
        r0 = rx_count; d0 = done_count;
        pulse_start();
        wait_done(2000, seen);
        end_of_dump(r0, d0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
